// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges unstallable load returns with buffered ALU results into one
// registered register-file write, and tracks in-flight destination registers for hazard stalls.
module wb_arbiter #(
    parameter int ADDR_WIDTH    = 3,
    parameter int DATA_WIDTH    = 16,
    parameter int REG_FILE_SIZE = 8,
    parameter int FIFO_DEPTH    = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               alu_valid,
    output logic                               alu_ready,
    input  logic [ADDR_WIDTH-1:0]              alu_addr,
    input  logic [DATA_WIDTH-1:0]              alu_data,
    input  logic                               ld_issue,
    input  logic [ADDR_WIDTH-1:0]              ld_issue_addr,
    input  logic                               ld_valid,
    input  logic [ADDR_WIDTH-1:0]              ld_addr,
    input  logic [DATA_WIDTH-1:0]              ld_data,
    output logic                               reg_w_en,
    output logic [ADDR_WIDTH-1:0]              reg_w_addr,
    output logic [DATA_WIDTH-1:0]              reg_w_data,
    output logic [REG_FILE_SIZE-1:0]           busy_mask,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
    output logic                               err
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    logic [ADDR_WIDTH-1:0]    fifo_addr [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]    fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]         rd_ptr;
    logic [PTR_W-1:0]         wr_ptr;
    logic                     fifo_empty;
    logic                     alu_acc_p0;
    logic                     pop_p0;
    logic                     push_p0;
    logic                     vld_p0;
    logic [ADDR_WIDTH-1:0]    sel_addr_p0;
    logic [DATA_WIDTH-1:0]    sel_data_p0;
    logic [REG_FILE_SIZE-1:0] busy_next;

    // Stage p0: source selection. Ready depends only on occupancy and ld_valid, never on alu_valid.
    assign fifo_empty = (fifo_count == '0);
    assign alu_ready  = (fifo_count < DEPTH_C) || (!fifo_empty && !ld_valid);
    assign alu_acc_p0 = alu_valid && alu_ready;
    assign pop_p0     = !ld_valid && !fifo_empty;
    assign push_p0    = alu_acc_p0 && (ld_valid || !fifo_empty);

    always_comb begin
        vld_p0      = 1'b1;
        sel_addr_p0 = ld_addr;
        sel_data_p0 = ld_data;
        if (ld_valid) begin
            vld_p0 = 1'b1;
        end else if (!fifo_empty) begin
            sel_addr_p0 = fifo_addr[rd_ptr];
            sel_data_p0 = fifo_data[rd_ptr];
        end else if (alu_acc_p0) begin
            sel_addr_p0 = alu_addr;
            sel_data_p0 = alu_data;
        end else begin
            vld_p0 = 1'b0;
        end
    end

    // Clear for the write now on reg_w_* is applied first so a same-cycle set wins.
    always_comb begin
        busy_next = busy_mask;
        if (reg_w_en)   busy_next[reg_w_addr]    = 1'b0;
        if (ld_issue)   busy_next[ld_issue_addr] = 1'b1;
        if (alu_acc_p0) busy_next[alu_addr]      = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            busy_mask  <= '0;
            err        <= 1'b0;
            reg_w_en   <= 1'b0;
            reg_w_addr <= '0;
            reg_w_data <= '0;
        end else begin
            if (pop_p0)  rd_ptr <= ptr_inc(rd_ptr);
            if (push_p0) wr_ptr <= ptr_inc(wr_ptr);
            if (push_p0 && !pop_p0)      fifo_count <= fifo_count + CNT_W'(1);
            else if (pop_p0 && !push_p0) fifo_count <= fifo_count - CNT_W'(1);
            busy_mask <= busy_next;
            if (ld_valid && !busy_mask[ld_addr]) err <= 1'b1;
            // Stage p1: registered write port; address/data hold when idle.
            reg_w_en <= vld_p0;
            if (vld_p0) begin
                reg_w_addr <= sel_addr_p0;
                reg_w_data <= sel_data_p0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_p0) begin
            fifo_addr[wr_ptr] <= alu_addr;
            fifo_data[wr_ptr] <= alu_data;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed and randomized bench for wb_arbiter against a queue-based reference model.
module tb_wb_arbiter;

    localparam int FD = 2;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [2:0]  alu_addr;
    logic [15:0] alu_data;
    logic        ld_issue;
    logic [2:0]  ld_issue_addr;
    logic        ld_valid;
    logic [2:0]  ld_addr;
    logic [15:0] ld_data;
    logic        reg_w_en;
    logic [2:0]  reg_w_addr;
    logic [15:0] reg_w_data;
    logic [7:0]  busy_mask;
    logic [1:0]  fifo_count;
    logic        err;

    int checks = 0;
    int errors = 0;

    // Reference model: pending ALU results as a queue, expected write port and scoreboard.
    logic [7:0]  m_busy;
    logic        m_err;
    logic        m_en;
    logic [2:0]  m_addr;
    logic [15:0] m_data;
    logic [18:0] q[$];

    wb_arbiter #(
        .ADDR_WIDTH(3), .DATA_WIDTH(16), .REG_FILE_SIZE(8), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .ld_issue(ld_issue), .ld_issue_addr(ld_issue_addr),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
        .reg_w_en(reg_w_en), .reg_w_addr(reg_w_addr), .reg_w_data(reg_w_data),
        .busy_mask(busy_mask), .fifo_count(fifo_count), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [2:0] aa, input logic [15:0] ad,
                         input logic li, input logic [2:0] lia,
                         input logic lv, input logic [2:0] la, input logic [15:0] ld);
        alu_valid = av; alu_addr = aa; alu_data = ad;
        ld_issue = li; ld_issue_addr = lia;
        ld_valid = lv; ld_addr = la; ld_data = ld;
    endtask

    task automatic idle();
        drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0);
    endtask

    task automatic model_reset();
        m_busy = '0; m_err = 1'b0; m_en = 1'b0; m_addr = '0; m_data = '0;
        q.delete();
    endtask

    // Called at a negedge with inputs driven; returns at the following negedge.
    task automatic step();
        logic       rdy;
        logic       acc;
        logic [7:0] nb;
        logic [18:0] e;
        #1;
        rdy = (q.size() < FD) || (q.size() > 0 && !ld_valid);
        check("alu_ready", alu_ready, rdy);
        acc = alu_valid && rdy;
        nb = m_busy;
        if (m_en) nb[m_addr] = 1'b0;
        if (ld_issue) nb[ld_issue_addr] = 1'b1;
        if (acc) nb[alu_addr] = 1'b1;
        if (ld_valid && !m_busy[ld_addr]) m_err = 1'b1;
        m_en = 1'b1;
        if (ld_valid) begin
            m_addr = ld_addr; m_data = ld_data;
            if (acc) q.push_back({alu_addr, alu_data});
        end else if (q.size() > 0) begin
            e = q.pop_front();
            {m_addr, m_data} = e;
            if (acc) q.push_back({alu_addr, alu_data});
        end else if (acc) begin
            m_addr = alu_addr; m_data = alu_data;
        end else begin
            m_en = 1'b0;
        end
        m_busy = nb;
        @(posedge clk);
        #1;
        check("reg_w_en", reg_w_en, m_en);
        check("reg_w_addr", reg_w_addr, m_addr);
        check("reg_w_data", reg_w_data, m_data);
        check("busy_mask", busy_mask, m_busy);
        check("fifo_count", fifo_count, q.size());
        check("err", err, m_err);
        @(negedge clk);
    endtask

    // Asynchronous reset asserted away from any clock edge; outputs must clear at once.
    task automatic apply_reset();
        idle();
        rst = 1'b1;
        #1;
        check("rst_en", reg_w_en, 1'b0);
        check("rst_addr", reg_w_addr, 3'd0);
        check("rst_data", reg_w_data, 16'h0);
        check("rst_busy", busy_mask, 8'h00);
        check("rst_count", fifo_count, 2'd0);
        check("rst_err", err, 1'b0);
        check("rst_ready", alu_ready, 1'b1);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        idle();
        model_reset();
        @(negedge clk);
        apply_reset();

        // Two ALU results buffered behind loads, then reset mid-operation.
        drive(1'b1, 3'd1, 16'h0011, 1'b0, 3'd0, 1'b1, 3'd0, 16'hAAAA);
        step();
        drive(1'b1, 3'd2, 16'h0022, 1'b0, 3'd0, 1'b1, 3'd0, 16'hBBBB);
        step();
        check("t1_count", fifo_count, 2'd2);
        check("t1_busy", busy_mask, 8'h06);
        apply_reset();

        // Bypass.
        drive(1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0);
        step();
        check("t2_en", reg_w_en, 1'b1);
        check("t2_addr", reg_w_addr, 3'd3);
        check("t2_data", reg_w_data, 16'h1234);
        check("t2_busy_set", busy_mask[3], 1'b1);
        idle();
        step();
        check("t2_busy_clr", busy_mask[3], 1'b0);

        // Load/ALU conflict.
        drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd5, 1'b0, 3'd0, 16'h0);
        step();
        drive(1'b1, 3'd2, 16'h0001, 1'b0, 3'd0, 1'b1, 3'd5, 16'hBEEF);
        step();
        check("t3_ld_addr", reg_w_addr, 3'd5);
        check("t3_ld_data", reg_w_data, 16'hBEEF);
        check("t3_count", fifo_count, 2'd1);
        idle();
        step();
        check("t3_alu_en", reg_w_en, 1'b1);
        check("t3_alu_addr", reg_w_addr, 3'd2);
        check("t3_alu_data", reg_w_data, 16'h0001);
        step();
        check("t3_busy_idle", busy_mask, 8'h00);

        // Scoreboard lifetime of a load.
        drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd4, 1'b0, 3'd0, 16'h0);
        step();
        check("t6_set", busy_mask[4], 1'b1);
        idle();
        step();
        check("t6_hold", busy_mask[4], 1'b1);
        drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b1, 3'd4, 16'h4444);
        step();
        check("t6_en", reg_w_en, 1'b1);
        check("t6_busy_at_write", busy_mask[4], 1'b1);
        idle();
        step();
        check("t6_clr", busy_mask[4], 1'b0);
        check("t6_no_err", err, 1'b0);

        // Backpressure: four back-to-back loads while an ALU stream is offered.
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 3'd0, 16'h0, 1'b1, 3'(4 + i), 1'b0, 3'd0, 16'h0);
            step();
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, (i < 2) ? 3'(i) : 3'd2, (i < 2) ? 16'(16'hA000 + i) : 16'hA002,
                  1'b0, 3'd0, 1'b1, 3'(4 + i), 16'(16'h5000 + i));
            #1;
            check("t4_ready", alu_ready, (i < 2) ? 1'b1 : 1'b0);
            step();
        end
        idle();
        step();
        check("t4_drain0_addr", reg_w_addr, 3'd0);
        check("t4_drain0_data", reg_w_data, 16'hA000);
        step();
        check("t4_drain1_addr", reg_w_addr, 3'd1);
        check("t4_drain1_data", reg_w_data, 16'hA001);
        check("t4_empty", fifo_count, 2'd0);
        step();

        // Unexpected load return.
        drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b1, 3'd7, 16'h7777);
        step();
        check("t5_en", reg_w_en, 1'b1);
        check("t5_data", reg_w_data, 16'h7777);
        check("t5_err", err, 1'b1);
        idle();
        step();
        step();
        check("t5_sticky", err, 1'b1);
        apply_reset();

        // Randomized traffic with a mid-run reset.
        for (int n = 0; n < 400; n++) begin
            if (n == 200) apply_reset();
            drive(1'($urandom_range(0, 1)), 3'($urandom), 16'($urandom),
                  1'($urandom_range(0, 3) == 0), 3'($urandom),
                  1'($urandom_range(0, 9) < 3), 3'($urandom), 16'($urandom));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
